// File: rtl/mem_bus_master_pkg.sv
// rtl/mem_bus_master_pkg.sv - shared types and helpers for the sequencer bus master
package mips_bus_pkg;

    typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} bus_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - Avalon-MM style master/slave bus bundle
interface mem_bus_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata
    );
endinterface

// File: rtl/mem_bus_master_timeout_ctr.sv
// rtl/mem_bus_master_timeout_ctr.sv - wait-state counter with expiry flag (BUS_TIMEOUT_EN builds)
module bus_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (inc_i)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expired_o = inc_i && (count_q == LAST);
endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - sequencer-to-Avalon master, one outstanding access; BUS_TIMEOUT_EN adds wait-state abort
module mem_bus_master
    import mips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    mem_bus_master_if.master  avm
);
    bus_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [3:0]        be_q;
    logic              is_read_q;
    logic              load, capture, timeout_hit;

`ifdef BUS_TIMEOUT_EN
    bus_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q != BUS),
        .inc_i     ((state_q == BUS) && avm.avm_waitrequest),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_read && req_write) begin
                    state_d = ERR;
                end else if (req_read || req_write) begin
                    load    = 1'b1;
                    state_d = is_word_aligned(req_addr[1:0]) ? BUS : ERR;
                end
            end
            BUS: begin
                if (!avm.avm_waitrequest) begin
                    capture = is_read_q;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            is_read_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q    <= {req_addr[ADDR_W-1:2], 2'b00};
                wdata_q   <= req_wdata;
                be_q      <= req_be;
                is_read_q <= req_read;
            end
            if (capture)
                rdata_q <= avm.avm_readdata;
        end
    end

    // Strobes decode only registered state, so they never glitch on request edges.
    assign avm.avm_read       = (state_q == BUS) && is_read_q;
    assign avm.avm_write      = (state_q == BUS) && !is_read_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = be_q;

    // rst_n gating keeps stall low while reset is held even if requests stay high.
    assign stall       = rst_n && (((state_q == IDLE) && (req_read || req_write)) || (state_q == BUS));
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == DONE) && is_read_q;
    assign err         = (state_q == ERR);
endmodule
